gate_truth_sweeper: RTL and testbench
=====================================

Name:
gate_truth_sweeper

Overview:
- Self-checking stimulus stage that sits directly upstream of a combinational gate under test, for example nor_gate.
- Drives every input combination onto the gate's inputs in ascending binary order and samples the gate's output after a settle interval.
- Compares each sample against a parameterised expected truth table and reports pass/fail plus a mismatch count.
- Replaces hand-written per-combination stimulus with a reusable synthesizable sweeper.

Parameters:
- N_INPUTS, 2: number of gate inputs; legal range 1..4.
- SETTLE_CYCLES, 2: cycles an input vector is held before the output is sampled; must be >= 1.
- EXPECTED, 4'b0001: expected truth table, width 2**N_INPUTS; bit i is the expected output for input vector i. The default is NOR, where only index 0 (a=0, b=0) gives 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  single-cycle request to begin a sweep.
- gate_out  input  1  output of the gate under test.
- gate_in  output  N_INPUTS  input vector driven to the gate; gate_in[N_INPUTS-1] connects to the first input (a) of the gate.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  valid while done is high; 1 when mismatch_count == 0.
- mismatch_count  output  N_INPUTS+1  number of vectors whose sample differed from EXPECTED.
- result_vec  output  2**N_INPUTS  captured gate output per vector; bit i holds the sample for vector i.

Behaviour:
- Reset is asynchronous and active-high. It may arrive at any point, including mid-sweep. On reset:
  - state = IDLE.
  - gate_in, busy, done, pass, mismatch_count, result_vec, and the internal idx and cnt are all cleared to 0.
  - A sweep in progress is abandoned; no partial done is produced.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE, with idx=0, cnt=0, gate_in=0, busy=1.
  - mismatch_count and result_vec clear on the same edge.
- SETTLE:
  - gate_in = idx, held stable.
  - If cnt < SETTLE_CYCLES-1: cnt++ and stay.
  - Otherwise -> SAMPLE.
- SAMPLE (exactly one cycle):
  - result_vec[idx] <= gate_out.
  - If gate_out != EXPECTED[idx]: mismatch_count++.
  - If idx == 2**N_INPUTS-1 -> DONE, with busy=0, done=1, and pass computed including this vector's compare.
  - Otherwise idx++, cnt=0, -> SETTLE; the new gate_in appears on this edge.
- DONE:
  - Outputs hold.
  - start=1 -> same transition as from IDLE: done=0, pass=0, busy=1, counters cleared.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - busy is high for 2**N_INPUTS*(SETTLE_CYCLES+1) cycles; done rises on the following edge.
  - For N_INPUTS=2 and SETTLE_CYCLES=2, busy is high for 12 cycles.
- start while busy is ignored; there is no queueing.
- mismatch_count width N_INPUTS+1 holds up to 2**N_INPUTS, so it never wraps.
- idx is N_INPUTS bits wide. Its wrap from all-ones is never exercised because the terminal compare precedes the increment.
- gate_out is sampled only in SAMPLE; glitches during SETTLE have no effect.

Optional Feature:
- Macro: SWEEP_TRACE_EN.
- When defined, two extra outputs are added:
  - first_fail_idx, N_INPUTS bits: idx of the first mismatching vector.
  - first_fail_valid, 1 bit: set on the first mismatch.
- Both outputs:
  - are captured in SAMPLE only while first_fail_valid=0;
  - are cleared on reset and on every accepted start;
  - hold through DONE.
- When undefined, these ports and their registers do not exist and the core behaviour is unchanged.

Test Plan:
- Correct gate: defaults with a behavioural NOR on gate_out; pulse start -> gate_in sequences 0,1,2,3, each held 3 cycles. Then done=1, pass=1, mismatch_count=0, result_vec=4'b0001, with busy high for exactly 12 cycles.
- Wrong gate: gate_out driven by an OR instead -> done=1, pass=0, mismatch_count=4, result_vec=4'b1110. With SWEEP_TRACE_EN: first_fail_idx=0, first_fail_valid=1.
- Single stuck bit: NOR model except vector 2 returns 1 -> mismatch_count=1, result_vec=4'b0101, pass=0. With SWEEP_TRACE_EN: first_fail_idx=2.
- Start while busy: extra start pulses during the sweep -> no restart; done still rises exactly 12 cycles after the first start. A second start in DONE clears done/pass and reruns the sweep with identical results.
- Async reset mid-operation: assert rst between clock edges while gate_in=2 -> all outputs 0 immediately, before the next edge, and state=IDLE. After release, start produces a full clean sweep with pass=1.
- Parameter variant: N_INPUTS=3, SETTLE_CYCLES=1, EXPECTED=8'b00000001 with a 3-input NOR -> gate_in steps 0..7 at 2 cycles each, busy high for 16 cycles, pass=1.

Source files
------------

// File: rtl/gate_truth_sweeper_if.sv
// Bundle between the truth-table sweeper and the gate under test / observer.
// SWEEP_TRACE_EN adds the first-failure trace signals.
interface gate_truth_sweeper_if #(
   parameter int N_INPUTS = 2
);
   logic                    start;
   logic                    gate_out;
   logic [N_INPUTS-1:0]     gate_in;
   logic                    busy;
   logic                    done;
   logic                    pass;
   logic [N_INPUTS:0]       mismatch_count;
   logic [2**N_INPUTS-1:0]  result_vec;
`ifdef SWEEP_TRACE_EN
   logic [N_INPUTS-1:0]     first_fail_idx;
   logic                    first_fail_valid;
`endif

   modport master (
`ifdef SWEEP_TRACE_EN
      input  first_fail_idx,
      input  first_fail_valid,
`endif
      output start,
      output gate_out,
      input  gate_in,
      input  busy,
      input  done,
      input  pass,
      input  mismatch_count,
      input  result_vec
   );

   modport slave (
`ifdef SWEEP_TRACE_EN
      output first_fail_idx,
      output first_fail_valid,
`endif
      input  start,
      input  gate_out,
      output gate_in,
      output busy,
      output done,
      output pass,
      output mismatch_count,
      output result_vec
   );
endinterface

// File: rtl/gate_truth_sweeper.sv
// Sweeps all input vectors of a combinational gate and checks a truth table.
// Optional first-failure trace outputs are enabled by SWEEP_TRACE_EN.
module gate_truth_sweeper #(
   parameter int                     N_INPUTS      = 2,
   parameter int                     SETTLE_CYCLES = 2,
   parameter logic [2**N_INPUTS-1:0] EXPECTED      = 4'b0001
) (
   input logic                 clk,
   input logic                 rst,
   gate_truth_sweeper_if.slave bus
);
   localparam int NV = 2**N_INPUTS;
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [N_INPUTS-1:0] LAST = '1;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t              state, state_n;
   logic [N_INPUTS-1:0] idx;
   logic [CW-1:0]       cnt;
   logic [N_INPUTS-1:0] gate_in;
   logic                busy, done, pass;
   logic [N_INPUTS:0]   mcount;
   logic [NV-1:0]       result;
   logic                accept, last, miss, settled;
`ifdef SWEEP_TRACE_EN
   logic [N_INPUTS-1:0] ff_idx;
   logic                ff_valid;
`endif

   assign accept  = bus.start && (state == IDLE || state == DONE);
   assign last    = (idx == LAST);
   assign miss    = (bus.gate_out != EXPECTED[idx]);
   assign settled = (cnt >= CW'(SETTLE_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (bus.start) state_n = SETTLE;
         SETTLE:  if (settled) state_n = SAMPLE;
         SAMPLE:  state_n = last ? DONE : SETTLE;
         DONE:    if (bus.start) state_n = SETTLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         cnt      <= '0;
         gate_in  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         mcount   <= '0;
         result   <= '0;
`ifdef SWEEP_TRACE_EN
         ff_idx   <= '0;
         ff_valid <= 1'b0;
`endif
      end else if (accept) begin
         idx      <= '0;
         cnt      <= '0;
         gate_in  <= '0;
         busy     <= 1'b1;
         done     <= 1'b0;
         pass     <= 1'b0;
         mcount   <= '0;
         result   <= '0;
`ifdef SWEEP_TRACE_EN
         ff_idx   <= '0;
         ff_valid <= 1'b0;
`endif
      end else if (state == SETTLE) begin
         if (!settled) cnt <= cnt + CW'(1);
      end else if (state == SAMPLE) begin
         result[idx] <= bus.gate_out;
         if (miss) mcount <= mcount + (N_INPUTS + 1)'(1);
`ifdef SWEEP_TRACE_EN
         if (miss && !ff_valid) begin
            ff_idx   <= idx;
            ff_valid <= 1'b1;
         end
`endif
         // terminal vector is checked before idx could wrap
         if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (mcount == '0) && !miss;
         end else begin
            idx     <= idx + N_INPUTS'(1);
            gate_in <= idx + N_INPUTS'(1);
            cnt     <= '0;
         end
      end
   end

   assign bus.gate_in        = gate_in;
   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.pass           = pass;
   assign bus.mismatch_count = mcount;
   assign bus.result_vec     = result;
`ifdef SWEEP_TRACE_EN
   assign bus.first_fail_idx   = ff_idx;
   assign bus.first_fail_valid = ff_valid;
`endif
endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Scoreboard bench for gate_truth_sweeper: a 2-input and a 3-input instance
// driven by behavioural gates, checked against a truth-table reference model.
module tb_gate_truth_sweeper;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gate_truth_sweeper_if #(.N_INPUTS(2)) b2();
   gate_truth_sweeper_if #(.N_INPUTS(3)) b3();

   gate_truth_sweeper #(
      .N_INPUTS(2), .SETTLE_CYCLES(2), .EXPECTED(4'b0001)
   ) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

   gate_truth_sweeper #(
      .N_INPUTS(3), .SETTLE_CYCLES(1), .EXPECTED(8'b00000001)
   ) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

   typedef struct {
      logic [15:0] res;
      int          mc;
      bit          pass;
      int          ffi;
      bit          ffv;
      longint      t0;
   } exp_t;

   exp_t   q2[$], q3[$];
   exp_t   e2, e3;
   int     log2[$], log3[$];
   int     mode2 = 0, mode3 = 0;
   longint cyc = 0;
   int     tests = 0, fails = 0;
   logic   d2p = 1'b0, d3p = 1'b0;

   always @(posedge clk) cyc++;

   // mode 0: NOR, 1: OR, 2: NOR with vector 2 stuck at 1
   function automatic logic gate_fn(int v, int mode);
      case (mode)
         1:       return v != 0;
         2:       return (v == 0) || (v == 2);
         default: return v == 0;
      endcase
   endfunction

   assign b2.gate_out = gate_fn(int'(b2.gate_in), mode2);
   assign b3.gate_out = gate_fn(int'(b3.gate_in), mode3);

   function automatic exp_t model(int n, logic [15:0] tt, int mode, longint t0);
      exp_t e;
      e.res = '0; e.mc = 0; e.ffi = 0; e.ffv = 0; e.t0 = t0;
      for (int i = 0; i < (1 << n); i++) begin
         logic o;
         o = gate_fn(i, mode);
         e.res[i] = o;
         if (o != tt[i]) begin
            if (!e.ffv) begin e.ffv = 1; e.ffi = i; end
            e.mc++;
         end
      end
      e.pass = (e.mc == 0);
      return e;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic check_sweep(string tag, exp_t e, logic [15:0] res, int mc,
                              logic pass, int ffi, logic ffv, int lg[$],
                              int n, int s);
      bit seq_ok;
      chk({tag, " result_vec"}, res, e.res);
      chk({tag, " mismatch_count"}, mc, e.mc);
      chk({tag, " pass"}, pass, e.pass);
`ifdef SWEEP_TRACE_EN
      chk({tag, " first_fail_valid"}, ffv, e.ffv);
      if (e.ffv) chk({tag, " first_fail_idx"}, ffi, e.ffi);
`endif
      chk({tag, " done_latency"}, cyc - e.t0, (1 << n) * (s + 1));
      chk({tag, " busy_cycles"}, lg.size(), (1 << n) * (s + 1));
      seq_ok = 1;
      for (int k = 0; k < lg.size(); k++)
         if (lg[k] != k / (s + 1)) seq_ok = 0;
      chk({tag, " gate_in_sequence"}, seq_ok, 1);
   endtask

   always @(negedge clk) begin
      if (b2.busy) log2.push_back(int'(b2.gate_in));
      if (b2.done && !d2p) begin
         chk("dut2 expected_done", q2.size() > 0, 1);
         if (q2.size() > 0) begin
            e2 = q2.pop_front();
`ifdef SWEEP_TRACE_EN
            check_sweep("dut2", e2, 16'(b2.result_vec), int'(b2.mismatch_count),
                        b2.pass, int'(b2.first_fail_idx), b2.first_fail_valid,
                        log2, 2, 2);
`else
            check_sweep("dut2", e2, 16'(b2.result_vec), int'(b2.mismatch_count),
                        b2.pass, 0, 1'b0, log2, 2, 2);
`endif
         end
         log2.delete();
      end
      d2p = b2.done;
   end

   always @(negedge clk) begin
      if (b3.busy) log3.push_back(int'(b3.gate_in));
      if (b3.done && !d3p) begin
         chk("dut3 expected_done", q3.size() > 0, 1);
         if (q3.size() > 0) begin
            e3 = q3.pop_front();
`ifdef SWEEP_TRACE_EN
            check_sweep("dut3", e3, 16'(b3.result_vec), int'(b3.mismatch_count),
                        b3.pass, int'(b3.first_fail_idx), b3.first_fail_valid,
                        log3, 3, 1);
`else
            check_sweep("dut3", e3, 16'(b3.result_vec), int'(b3.mismatch_count),
                        b3.pass, 0, 1'b0, log3, 3, 1);
`endif
         end
         log3.delete();
      end
      d3p = b3.done;
   end

   task automatic go(int w, bit acc);
      @(negedge clk);
      if (w == 2) begin
         if (acc) q2.push_back(model(2, 16'h0001, mode2, cyc + 1));
         b2.start = 1'b1;
      end else begin
         if (acc) q3.push_back(model(3, 16'h0001, mode3, cyc + 1));
         b3.start = 1'b1;
      end
      @(negedge clk);
      b2.start = 1'b0;
      b3.start = 1'b0;
   endtask

   task automatic wait_done(int w, string nm);
      bit got;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = (w == 2) ? b2.done : b3.done;
      end
      chk({nm, " done_timeout"}, got, 1);
   endtask

   task automatic check_cleared(string tag);
      chk({tag, " gate_in"}, b2.gate_in, 0);
      chk({tag, " busy"}, b2.busy, 0);
      chk({tag, " done"}, b2.done, 0);
      chk({tag, " pass"}, b2.pass, 0);
      chk({tag, " mismatch_count"}, b2.mismatch_count, 0);
      chk({tag, " result_vec"}, b2.result_vec, 0);
`ifdef SWEEP_TRACE_EN
      chk({tag, " first_fail_valid"}, b2.first_fail_valid, 0);
      chk({tag, " first_fail_idx"}, b2.first_fail_idx, 0);
`endif
   endtask

   initial begin
      bit hit;
      rst = 1'b0;
      b2.start = 1'b0;
      b3.start = 1'b0;
      #2 rst = 1'b1;
      #1 check_cleared("reset");
      chk("reset dut3 done", b3.done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      mode2 = 0; go(2, 1); wait_done(2, "nor");
      mode2 = 1; go(2, 1); wait_done(2, "or");
      mode2 = 2; go(2, 1); wait_done(2, "stuck");

      mode2 = 0; go(2, 1);
      repeat (2) begin
         repeat ($urandom_range(1, 2)) @(negedge clk);
         go(2, 0);
      end
      wait_done(2, "start_while_busy");
      go(2, 1); wait_done(2, "rerun_from_done");

      mode2 = 0; go(2, 1);
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(posedge clk);
         #2 hit = (b2.gate_in == 2'd2);
      end
      chk("reached gate_in 2", hit, 1);
      rst = 1'b1;
      #1 check_cleared("async_reset");
      q2.delete();
      log2.delete();
      @(negedge clk);
      #1 rst = 1'b0;
      go(2, 1); wait_done(2, "after_reset");

      for (int it = 0; it < 6; it++) begin
         mode2 = int'($urandom_range(0, 2));
         go(2, 1);
         if ($urandom_range(0, 1) == 1) go(2, 0);
         wait_done(2, "random2");
      end

      for (int m = 0; m < 3; m++) begin
         mode3 = m; go(3, 1); wait_done(3, "variant");
      end
      for (int it = 0; it < 4; it++) begin
         mode3 = int'($urandom_range(0, 2));
         go(3, 1);
         if ($urandom_range(0, 1) == 1) go(3, 0);
         wait_done(3, "random3");
      end

      repeat (3) @(negedge clk);
      chk("dut2 scoreboard drained", q2.size(), 0);
      chk("dut3 scoreboard drained", q3.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
